// File: rtl/mul_defs_pkg.sv
// Shared definitions for the iterative multiplier: state encoding and the
// helper that sizes the iteration counter.
package mul_defs;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // ceil(log2(n)); returns 0 for n <= 1
   function automatic int clog2(input int n);
      int r;
      int v;
      r = 0;
      v = n - 1;
      while (v > 0) begin
         r++;
         v = v >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mul_seq_add.sv
// Generic W-bit adder. The multiplier uses a (W+1)-bit instance so the
// carry out of the partial-product add is kept.
module add #(
   parameter int W = 8
) (
   input  logic [W-1:0] in0,
   input  logic [W-1:0] in1,
   output logic [W-1:0] out0
);

   assign out0 = in0 + in1;

endmodule

// File: rtl/mul_seq.sv
// Iterative unsigned shift-and-add multiplier. One partial product per
// cycle; W iterations per operation; start/busy/done handshake.
module mul_seq
   import mul_defs::*;
#(
   parameter int W = 32
) (
   input  logic           clk,
   input  logic           rstn,
   input  logic           start,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic           busy,
   output logic           done,
   output logic [2*W-1:0] p
);

   localparam int CW = clog2(W) + 1;
   localparam logic [CW-1:0] LAST = CW'(W - 1);

   state_t        state, nstate;
   logic [W-1:0]  mcand, acc_hi, acc_lo;
   logic [CW-1:0] cnt;
   logic [W:0]    addend, sum;
   logic          accept, last;

   // DONE accepts a new start just like IDLE, so held start loses no cycle
   assign accept = start && ((state == IDLE) || (state == DONE));
   assign last   = (state == RUN) && (cnt == LAST);
   assign addend = acc_lo[0] ? {1'b0, mcand} : '0;

   add #(.W(W + 1)) u_add (
      .in0  ({1'b0, acc_hi}),
      .in1  (addend),
      .out0 (sum)
   );

   // next-state decode
   always_comb begin
      nstate = state;
      case (state)
         IDLE, DONE: nstate = start ? RUN : IDLE;
         RUN:        nstate = last ? DONE : RUN;
         default:    nstate = IDLE;
      endcase
   end

   // state register; busy/done are registered decodes of the next state
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= nstate;
         busy  <= (nstate == RUN);
         done  <= (nstate == DONE);
      end
   end

   // operand capture, shift/accumulate iteration and product load
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mcand  <= '0;
         acc_hi <= '0;
         acc_lo <= '0;
         cnt    <= '0;
         p      <= '0;
      end else if (accept) begin
         mcand  <= a;
         acc_lo <= b;
         acc_hi <= '0;
         cnt    <= '0;
      end else if (state == RUN) begin
         // {sum, acc_lo} >> 1: the adder carry lands in acc_hi's MSB
         acc_hi <= sum[W:1];
         acc_lo <= {sum[0], acc_lo[W-1:1]};
         cnt    <= cnt + 1'b1;
         if (last) p <= {sum, acc_lo[W-1:1]};
      end
   end

endmodule
